// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store unit sitting in front of data_mem.
// Converts byte/half/word loads and stores at byte addresses into word-indexed
// data_mem accesses (read-modify-write for sub-word stores), extends load data
// and reports malformed, out-of-range and (optionally) misaligned requests.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses fault without touching memory
//   undefined : low address bits are forced aligned and the access proceeds
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/load/store     request strobe and kind (exactly one of load/store)
//   req_size                 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned             zero-extend sub-word loads
//   req_addr, req_wdata      byte address, store data (sub-word from the LSBs)
//   busy                     unit not idle
//   resp_valid/resp_fault    one-cycle completion pulse, fault qualifier
//   resp_rdata               extended load data, held until the next load
//   mem_address              word index to data_mem
//   mem_writeData, mem_write write word and strobe
//   mem_read, mem_dataOut    read strobe, read data (one cycle after the read edge)
module load_store_unit #(
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_load,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        busy,
   output logic        resp_valid,
   output logic        resp_fault,
   output logic [31:0] resp_rdata,
   output logic [31:0] mem_address,
   output logic [31:0] mem_writeData,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [31:0] mem_dataOut
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_BAD  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_EXT  = 3'd2,
      S_MRG  = 3'd3,
      S_WR   = 3'd4,
      S_RSP  = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [15:0] sdata_q;
   logic [1:0]  size_q;
   logic [1:0]  off_q;
   logic        load_q;
   logic        unsigned_q;
   logic        fault_q;

   logic        cmd_ok_c;
   logic        range_bad_c;
   logic        misalign_c;
   logic        fault_c;
   logic [1:0]  off_c;
   logic [7:0]  lane_b_c;
   logic [15:0] lane_h_c;
   logic [31:0] ext_c;
   logic [31:0] merge_c;

   // Request classification and effective lane offset at acceptance
   always_comb begin
      cmd_ok_c    = (req_load ^ req_store) && (req_size != SZ_BAD);
      range_bad_c = {2'b00, req_addr[31:2]} >= 32'(MEM_DEPTH);
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_c  = ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
      misalign_c  = 1'b0;
`endif
      fault_c     = !cmd_ok_c || range_bad_c || misalign_c;
      // Wider accesses drop the low address bits (forced alignment)
      case (req_size)
         SZ_BYTE: off_c = req_addr[1:0];
         SZ_HALF: off_c = {req_addr[1], 1'b0};
         default: off_c = 2'b00;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (fault_c)                  state_d = S_RSP;
               else if (req_load)            state_d = S_RD;
               else if (req_size == SZ_WORD) state_d = S_WR;
               else                          state_d = S_RD;
            end
         end
         S_RD:    state_d = load_q ? S_EXT : S_MRG;
         S_EXT:   state_d = S_RSP;
         S_MRG:   state_d = S_WR;
         S_WR:    state_d = S_RSP;
         S_RSP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs, decoded from the state register only
   always_comb begin
      busy       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      resp_valid = 1'b0;
      resp_fault = 1'b0;
      case (state_q)
         S_IDLE:  ;
         S_RD:    begin busy = 1'b1; mem_read  = 1'b1; end
         S_WR:    begin busy = 1'b1; mem_write = 1'b1; end
         S_RSP:   begin busy = 1'b1; resp_valid = 1'b1; resp_fault = fault_q; end
         default: busy = 1'b1;
      endcase
   end

   // Big-endian lane extraction, extension and sub-word merge
   always_comb begin
      case (off_q)
         2'd0:    lane_b_c = mem_dataOut[31:24];
         2'd1:    lane_b_c = mem_dataOut[23:16];
         2'd2:    lane_b_c = mem_dataOut[15:8];
         default: lane_b_c = mem_dataOut[7:0];
      endcase
      lane_h_c = off_q[1] ? mem_dataOut[15:0] : mem_dataOut[31:16];

      case (size_q)
         SZ_BYTE: ext_c = unsigned_q ? {24'h0, lane_b_c} : {{24{lane_b_c[7]}}, lane_b_c};
         SZ_HALF: ext_c = unsigned_q ? {16'h0, lane_h_c} : {{16{lane_h_c[15]}}, lane_h_c};
         default: ext_c = mem_dataOut;
      endcase

      merge_c = mem_dataOut;
      case (size_q)
         SZ_BYTE: begin
            case (off_q)
               2'd0:    merge_c[31:24] = sdata_q[7:0];
               2'd1:    merge_c[23:16] = sdata_q[7:0];
               2'd2:    merge_c[15:8]  = sdata_q[7:0];
               default: merge_c[7:0]   = sdata_q[7:0];
            endcase
         end
         SZ_HALF: begin
            if (off_q[1]) merge_c[15:0]  = sdata_q;
            else          merge_c[31:16] = sdata_q;
         end
         default: ;
      endcase
   end

   // Request capture, load result and write word registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         rdata_q    <= 32'h0;
         sdata_q    <= 16'h0;
         size_q     <= 2'b00;
         off_q      <= 2'b00;
         load_q     <= 1'b0;
         unsigned_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q     <= {2'b00, req_addr[31:2]};
                  load_q     <= req_load;
                  size_q     <= req_size;
                  unsigned_q <= req_unsigned;
                  off_q      <= off_c;
                  sdata_q    <= req_wdata[15:0];
                  fault_q    <= fault_c;
                  if (!fault_c && req_store && (req_size == SZ_WORD))
                     wdata_q <= req_wdata;
               end
            end
            S_EXT:   rdata_q <= ext_c;
            S_MRG:   wdata_q <= merge_c;
            default: ;
         endcase
      end
   end

   assign mem_address   = addr_q;
   assign mem_writeData = wdata_q;
   assign resp_rdata    = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed and random requests against a
// byte-addressed big-endian reference memory, with a scoreboard queue checked
// by an independent response/strobe monitor.
module tb_load_store_unit;

   localparam int unsigned DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_load, req_store, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        busy, resp_valid, resp_fault, mem_write, mem_read;
   logic [31:0] resp_rdata, mem_address, mem_writeData, mem_dataOut;

   load_store_unit #(.MEM_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .busy(busy), .resp_valid(resp_valid), .resp_fault(resp_fault),
      .resp_rdata(resp_rdata), .mem_address(mem_address),
      .mem_writeData(mem_writeData), .mem_write(mem_write),
      .mem_read(mem_read), .mem_dataOut(mem_dataOut)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          fault;
      logic [31:0] rdata;
      int          lat;
      int          nrd;
      int          nwr;
      logic [31:0] widx;
      int          e0;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   logic [7:0]  ref_b [DEPTH*4];
   logic [31:0] envmem [DEPTH];
   logic [31:0] last_rd;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   int          nrd = 0;
   int          nwr = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // data_mem stand-in: synchronous write, registered read
   always @(posedge clk) begin
      if (mem_write && (mem_address < DEPTH)) envmem[mem_address[5:0]] <= mem_writeData;
      if (mem_read) mem_dataOut <= (mem_address < DEPTH) ? envmem[mem_address[5:0]] : 32'h0;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: byte-array memory, big-endian byte numbering
   function automatic exp_t model(bit ld, bit st, logic [1:0] sz, bit uns,
                                  logic [31:0] a, logic [31:0] wd);
      exp_t        e;
      int          n;
      logic [31:0] v;
      logic [31:0] ba;
      e.widx  = a >> 2;
      e.fault = (ld == st) || (sz == 2'd3) || ((a >> 2) >= DEPTH);
      e.lat   = 0;
      e.nrd   = 0;
      e.nwr   = 0;
      e.e0    = 0;
      n       = 1 << sz;
`ifdef LSU_MISALIGN_TRAP_EN
      if (!e.fault && (a % n != 0)) e.fault = 1'b1;
      ba = a;
`else
      ba = a - (a % n);
`endif
      if (!e.fault) begin
         if (ld) begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_b[ba + i]);
            if (!uns && (n < 4) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            last_rd = v;
            e.lat   = 2;
            e.nrd   = 1;
         end else begin
            for (int i = 0; i < n; i++) ref_b[ba + i] = 8'(wd >> (8*(n-1-i)));
            e.nwr = 1;
            e.nrd = (n < 4) ? 1 : 0;
            e.lat = (n < 4) ? 3 : 1;
         end
      end
      e.rdata = last_rd;
      return e;
   endfunction

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = 1'b0;
      last_rd   = 32'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic issue(bit ld, bit st, logic [1:0] sz, bit uns,
                        logic [31:0] a, logic [31:0] wd);
      exp_t e;
      int   t;
      @(negedge clk);
      e    = model(ld, st, sz, uns, a, wd);
      e.e0 = cyc + 1;
      q.push_back(e);
      req_valid = 1'b1; req_load = ld; req_store = st; req_size = sz;
      req_unsigned = uns; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      // Random traffic while busy must be ignored
      req_valid    = 1'($urandom_range(0, 1));
      req_load     = 1'($urandom);
      req_store    = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
      t = 0;
      while (q.size() != 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      req_valid = 1'b0;
      if (q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout: no response after %0d cycles", t);
         q.delete();
         do_reset();
      end
   endtask

   // Monitor: strobe legality and address, response contents and timing
   always @(negedge clk) begin
      if (rst) begin
         nrd = 0;
         nwr = 0;
      end else begin
         if (mem_read || mem_write) begin
            chk("rd_wr_overlap", 32'(mem_read & mem_write), 32'h0);
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL stray_strobe: rd=%0b wr=%0b with no request", mem_read, mem_write);
            end else begin
               chk("mem_address", mem_address, q[0].widx);
            end
            nrd += int'(mem_read);
            nwr += int'(mem_write);
         end
         if (resp_valid) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL stray_resp: resp_valid=1 with no request");
            end else begin
               mon_e = q.pop_front();
               chk("resp_fault", 32'(resp_fault), 32'(mon_e.fault));
               chk("resp_rdata", resp_rdata, mon_e.rdata);
               chk("latency", 32'(cyc - mon_e.e0), 32'(mon_e.lat));
               chk("n_reads", 32'(nrd), 32'(mon_e.nrd));
               chk("n_writes", 32'(nwr), 32'(mon_e.nwr));
            end
            nrd = 0;
            nwr = 0;
         end
      end
   end

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_busy"},       32'(busy), 32'h0);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
      chk({tag, "_resp_fault"}, 32'(resp_fault), 32'h0);
      chk({tag, "_mem_read"},   32'(mem_read), 32'h0);
      chk({tag, "_mem_write"},  32'(mem_write), 32'h0);
      chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
      chk({tag, "_mem_address"}, mem_address, 32'h0);
      chk({tag, "_mem_writeData"}, mem_writeData, 32'h0);
   endtask

   initial begin
      logic [31:0] v;
      exp_t        d;
      logic        ld, st;
      logic [1:0]  sz;
      logic [31:0] a;
      int          r;

      rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
      req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      last_rd = 32'h0;
      for (int w = 0; w < DEPTH; w++) begin
         v = $urandom;
         envmem[w] <= v;
         for (int k = 0; k < 4; k++) ref_b[4*w + k] = 8'(v >> (24 - 8*k));
      end
      #1;
      chk_outputs_zero("reset");
      do_reset();

      // Directed sequence
      issue(0, 1, 2'd2, 0, 32'h10, 32'h1122_3344);
      issue(1, 0, 2'd0, 0, 32'h11, 32'h0);
      issue(0, 1, 2'd0, 0, 32'h13, 32'h0000_00AB);
      issue(1, 0, 2'd2, 0, 32'h10, 32'h0);
      issue(0, 1, 2'd2, 0, 32'h10, 32'h80FF_7F01);
      issue(1, 0, 2'd0, 0, 32'h10, 32'h0);
      issue(1, 0, 2'd0, 1, 32'h10, 32'h0);
      issue(1, 0, 2'd1, 0, 32'h12, 32'h0);
      issue(1, 0, 2'd1, 1, 32'h10, 32'h0);
      issue(0, 1, 2'd1, 0, 32'h16, 32'hDEAD_BEEF);
      issue(1, 0, 2'd2, 0, 32'h14, 32'h0);
      issue(1, 0, 2'd2, 0, 32'h02, 32'h0);
      issue(1, 0, 2'd1, 0, 32'h13, 32'h0);
      issue(1, 0, 2'd2, 0, 32'(4*DEPTH), 32'h0);
      issue(0, 1, 2'd0, 0, 32'(4*DEPTH + 1), 32'h5);
      issue(1, 1, 2'd2, 0, 32'h0, 32'h0);
      issue(0, 0, 2'd0, 0, 32'h0, 32'h0);
      issue(1, 0, 2'd3, 0, 32'h4, 32'h0);

      // Random traffic concentrated on a few words
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 19);
         if (r < 9)       begin ld = 1'b1; st = 1'b0; end
         else if (r < 18) begin ld = 1'b0; st = 1'b1; end
         else             begin ld = 1'(r == 18); st = 1'(r == 18); end
         sz = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         r  = $urandom_range(0, 24);
         if (r == 0)      a = 32'(4*DEPTH) + 32'($urandom_range(0, 4000));
         else if (r == 1) a = $urandom;
         else             a = 32'($urandom_range(0, 31));
         issue(ld, st, sz, 1'($urandom), a, $urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Reset during the merge cycle of a byte store: dropped, no write
      @(negedge clk);
      d.fault = 1'b0; d.rdata = 32'h0; d.lat = 0; d.nrd = 0; d.nwr = 0;
      d.widx = 32'h8; d.e0 = 0;
      q.push_back(d);
      req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = 32'h21; req_wdata = 32'h5A;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      q.delete();
      #1;
      chk_outputs_zero("midreset");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      last_rd = 32'h0;
      issue(1, 0, 2'd2, 0, 32'h20, 32'h0);

      repeat (3) @(negedge clk);
      for (int w = 0; w < DEPTH; w++)
         chk($sformatf("mem_word_%0d", w), envmem[w],
             {ref_b[4*w], ref_b[4*w + 1], ref_b[4*w + 2], ref_b[4*w + 3]});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit placed directly upstream of `data_mem`. It accepts byte, halfword and word load and store requests at byte addresses from the MIPS32 pipeline. It converts each request into word-indexed accesses on the `data_mem` port, performing read-modify-write for sub-word stores. Load results are sign- or zero-extended, and the unit signals misaligned or out-of-range accesses.

## Interface
- `MEM_DEPTH`, default 256: number of 32-bit words in `data_mem`; word index must be < `MEM_DEPTH`.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset. Clock is `clk`.
- `req_valid` in 1: request present. Sampled only in IDLE.
- `req_load` in 1: load request.
- `req_store` in 1: store request.
- `req_size` in 2: access size. 00 = byte, 01 = half, 10 = word; 11 is illegal.
- `req_unsigned` in 1: zero-extend loaded data (LBU/LHU); ignored for word and stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; sub-word data is taken from the LSBs.
- `busy` out 1: high whenever the state is not IDLE.
- `resp_valid` out 1: one-cycle completion pulse for every accepted request.
- `resp_fault` out 1: qualifies `resp_valid`; the request was rejected.
- `resp_rdata` out 32: extended load data; holds its value until the next load response.
- `mem_address` out 32: word index, `{2'b00, addr[31:2]}`.
- `mem_writeData` out 32: word written to memory.
- `mem_write` out 1: memory write strobe.
- `mem_read` out 1: memory read strobe.
- `mem_dataOut` in 32: memory read data, valid in the cycle after a `mem_read` edge.

## Operation
- Byte order is big-endian.
  - Byte offset k occupies bits [31-8k : 24-8k].
  - Half offset 0 occupies bits 31:16; half offset 2 occupies bits 15:0.
- States: IDLE, RD, EXT, MRG, WR, RSP.
- Acceptance: in IDLE, with `req_valid`=1, exactly one of `req_load`/`req_store` high, and `req_size` not 11.
  - The address, data and control fields are registered at the accepting edge.
  - `req_valid` outside IDLE is ignored; requests are never queued.
- Fault. The request is rejected with no memory strobe if either condition holds:
  - `req_valid` with both or neither of load/store set, or `req_size`=11.
  - Word index ≥ `MEM_DEPTH`.
  - On rejection, go to RSP with `resp_fault`=1.
- Alignment handling is set by `LSU_MISALIGN_TRAP_EN` (see Configuration).
- Load: IDLE → RD → EXT → RSP → IDLE.
  - RD drives `mem_read`=1.
  - In EXT, the selected lane is extracted from `mem_dataOut`, extended, and registered into `resp_rdata`.
- Word store: IDLE → WR → RSP → IDLE.
  - WR drives `mem_write`=1 with `mem_writeData`=`req_wdata`.
- Sub-word store: IDLE → RD → MRG → WR → RSP → IDLE.
  - MRG replaces only the addressed lane of `mem_dataOut` and registers the merged word.
- RSP: `resp_valid`=1 for exactly one cycle, then return to IDLE.
- `mem_read` and `mem_write` are never high together. `mem_address` is stable for the whole operation.
- Reset values:
  - `busy`, `resp_valid`, `resp_fault`, `mem_read`, `mem_write` = 0.
  - `resp_rdata`, `mem_address`, `mem_writeData` = 0.
  - State = IDLE.
- Reset mid-operation drops the request immediately. No write is issued and no response is produced.

## Timing
- The accept edge is E0.
- Load latency: `resp_valid` is high in the cycle after E2 (E0 → E1 memory read edge → E2 data captured).
- Word store: write committed at E1; `resp_valid` is high in the cycle after E1.
- Sub-word store: read at E1, merge at E2, write committed at E3; `resp_valid` is high in the cycle after E3.
- Fault: `resp_valid`/`resp_fault` are high in the cycle after E0.
- Throughput: the next request can be accepted at the edge ending the RSP cycle.
  - Minimum spacing is 4 cycles for loads, 3 for word stores, 5 for sub-word stores, and 2 for faults.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A half access with `addr[0]`=1 or a word access with `addr[1:0]`≠0 faults: no memory access, `resp_fault`=1.
- Undefined:
  - Low address bits are forced aligned: half ignores `addr[0]`, word ignores `addr[1:0]`.
  - The access proceeds normally and never faults for alignment.

## Test plan
- Store word 0x11223344 to addr 0x10, then LB addr 0x11 → `mem_address`=4, write at E1, `resp_rdata`=0x00000022 in the cycle after E2.
- Memory word 4 = 0x80FF7F01. LB addr 0x10 → 0xFFFFFF80; LBU addr 0x10 → 0x00000080; LH addr 0x12 → 0x00007F01; LHU addr 0x10 → 0x000080FF.
- SB 0xAB to addr 0x13 over 0x11223344 → RD, MRG, then write 0x112233AB at E3, one `resp_valid`, `mem_read`/`mem_write` never overlapping.
- LW addr 0x02:
  - With `LSU_MISALIGN_TRAP_EN`: `resp_valid`=`resp_fault`=1 in the cycle after E0, no strobes.
  - Without: reads word 0.
- Word index ≥ `MEM_DEPTH` (addr 4×`MEM_DEPTH`), or load+store both set → fault pulse, no strobes.
- Assert `rst` during MRG of an SB → all outputs 0 immediately, no `mem_write`, no `resp_valid`. A following LW after reset completes normally.
